// File: rtl/zero_count_printer.sv
// Deserialises an MSB-first nibble frame, converts it to decimal with a serial
// double-dabble and prints it as ASCII digits followed by CR LF on a valid/ready byte port.
module zero_count_printer #(
  parameter int NIBBLES        = 8,
  parameter int DIGITS         = 10,
  parameter bit SUPPRESS_ZEROS = 1'b1,
  parameter bit EMIT_ON_CHANGE = 1'b1
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic [3:0]             data_in,
  input  logic                   frame_start,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [4*NIBBLES-1:0]   value_out,
  output logic                   value_valid,
  output logic                   busy,
  output logic                   frame_dropped
);

  localparam int W   = 4 * NIBBLES;
  localparam int BW  = 4 * DIGITS;
  localparam int CW  = $clog2(NIBBLES + 1);
  localparam int IW  = $clog2(DIGITS);
  localparam int CVW = $clog2(W);

  typedef enum logic [2:0] {IDLE, CONVERT, EMIT, CR, LF} state_t;

  // One shift-add-3 step over the whole {bcd, bin} register.
  function automatic logic [BW+W-1:0] dabble_step(input logic [BW-1:0] bcd, input logic [W-1:0] bin);
    logic [BW-1:0] adj;
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = adj[4*i +: 4];
      end
    end
    return {adj, bin} << 1;
  endfunction

  // Returns {show, ascii} for digit idx; a hidden digit is a leading zero being skipped.
  function automatic logic [8:0] emit_view(input logic [BW-1:0] bcd, input logic [IW-1:0] idx,
                                           input logic seen);
    logic [3:0] d;
    logic       show;
    d    = bcd[{idx, 2'b00} +: 4];
    show = !(SUPPRESS_ZEROS && (d == 4'd0) && !seen && (idx != {IW{1'b0}}));
    return {show, 8'h30 + {4'h0, d}};
  endfunction

  logic            cap_active_r;
  logic [CW-1:0]   cnt_r;
  logic [W-1:0]    shreg_r;
  logic [W-1:0]    pend_r;
  logic            pend_v_r;
  logic [W-1:0]    frame_s;
  logic            complete_s;
  logic            consume_s;

  state_t          state_r;
  logic [W-1:0]    bin_r;
  logic [BW-1:0]   bcd_r;
  logic [W-1:0]    last_val_r;
  logic            first_r;
  logic [CVW-1:0]  cyc_r;
  logic [IW-1:0]   idx_r;
  logic            seen_r;
  logic [BW+W-1:0] step_s;

  // Frame assembly, completion detect and handshake with the printer FSM.
  always_comb begin
    frame_s    = {shreg_r[W-5:0], data_in};
    complete_s = cap_active_r && !frame_start && (cnt_r == CW'(NIBBLES - 1));
    consume_s  = (state_r == IDLE) && pend_v_r;
    step_s     = dabble_step(bcd_r, bin_r);
  end

  // Capture shift register and the single-entry pending frame slot.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cap_active_r  <= 1'b0;
      cnt_r         <= {CW{1'b0}};
      shreg_r       <= {W{1'b0}};
      pend_r        <= {W{1'b0}};
      pend_v_r      <= 1'b0;
      value_out     <= {W{1'b0}};
      value_valid   <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      value_valid   <= 1'b0;
      frame_dropped <= 1'b0;
      if (frame_start) begin
        shreg_r      <= W'(data_in);
        cnt_r        <= CW'(1);
        cap_active_r <= 1'b1;
      end else if (cap_active_r) begin
        shreg_r <= frame_s;
        cnt_r   <= cnt_r + CW'(1);
        if (complete_s) cap_active_r <= 1'b0;
      end
      // A completion on the same edge the FSM consumes refills the slot without a drop.
      if (complete_s) begin
        value_out     <= frame_s;
        value_valid   <= 1'b1;
        pend_r        <= frame_s;
        pend_v_r      <= 1'b1;
        frame_dropped <= pend_v_r && !consume_s;
      end else if (consume_s) begin
        pend_v_r <= 1'b0;
      end
    end
  end

  // Printer FSM: tx_valid/tx_data are loaded with look-ahead so a shown digit is valid on entry.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r    <= IDLE;
      bin_r      <= {W{1'b0}};
      bcd_r      <= {BW{1'b0}};
      last_val_r <= {W{1'b0}};
      first_r    <= 1'b1;
      cyc_r      <= {CVW{1'b0}};
      idx_r      <= {IW{1'b0}};
      seen_r     <= 1'b0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pend_v_r) begin
            if (EMIT_ON_CHANGE && !first_r && (pend_r == last_val_r)) begin
              state_r <= IDLE;
            end else begin
              bin_r      <= pend_r;
              bcd_r      <= {BW{1'b0}};
              last_val_r <= pend_r;
              first_r    <= 1'b0;
              cyc_r      <= {CVW{1'b0}};
              state_r    <= CONVERT;
              busy       <= 1'b1;
            end
          end
        end
        CONVERT: begin
          {bcd_r, bin_r} <= step_s;
          cyc_r          <= cyc_r + CVW'(1);
          if (cyc_r == CVW'(W - 1)) begin
            state_r             <= EMIT;
            idx_r               <= IW'(DIGITS - 1);
            seen_r              <= 1'b0;
            {tx_valid, tx_data} <= emit_view(step_s[BW+W-1:W], IW'(DIGITS - 1), 1'b0);
          end
        end
        EMIT: begin
          if (tx_valid) begin
            if (tx_ready) begin
              seen_r <= 1'b1;
              if (idx_r == {IW{1'b0}}) begin
                state_r <= CR;
                tx_data <= 8'h0D;
              end else begin
                idx_r               <= idx_r - IW'(1);
                {tx_valid, tx_data} <= emit_view(bcd_r, idx_r - IW'(1), 1'b1);
              end
            end
          end else begin
            idx_r               <= idx_r - IW'(1);
            {tx_valid, tx_data} <= emit_view(bcd_r, idx_r - IW'(1), seen_r);
          end
        end
        CR: begin
          if (tx_ready) begin
            tx_data <= 8'h0A;
            state_r <= LF;
          end
        end
        LF: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zero_count_printer.sv
// Directed bench for zero_count_printer: frames are sent as nibble streams and the
// accepted byte stream is compared against hand-written ASCII lines.
module tb_zero_count_printer;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  data_in = 4'h0;
  logic        frame_start = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [31:0] value_out;
  logic        value_valid;
  logic        busy;
  logic        frame_dropped;

  int n_checks = 0;
  int n_fail = 0;

  int           rx_cnt = 0;
  logic [127:0] rx_word = '0;
  int           vv_cnt = 0;
  int           drop_cnt = 0;
  int           stab_viol = 0;
  logic         hold = 1'b0;
  logic [7:0]   held = 8'h00;

  zero_count_printer dut (
    .sys_clk(sys_clk), .rst(rst), .data_in(data_in), .frame_start(frame_start),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .value_out(value_out), .value_valid(value_valid), .busy(busy),
    .frame_dropped(frame_dropped)
  );

  always #5 sys_clk = ~sys_clk;

  // Sink model: collects accepted bytes and watches that a stalled byte stays put.
  always @(posedge sys_clk) begin
    if (tx_valid && tx_ready && !rst) begin
      rx_word <= {rx_word[119:0], tx_data};
      rx_cnt  <= rx_cnt + 1;
    end
    if (value_valid) vv_cnt <= vv_cnt + 1;
    if (frame_dropped) drop_cnt <= drop_cnt + 1;
    if (hold && (tx_valid !== 1'b1 || tx_data !== held)) stab_viol <= stab_viol + 1;
    hold <= tx_valid && !tx_ready && !rst;
    held <= tx_data;
  end

  task automatic do_reset();
    @(negedge sys_clk);
    rst = 1'b1; frame_start = 1'b0; data_in = 4'h0;
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] v);
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      frame_start = (i == 0);
      data_in     = v[31-4*i -: 4];
    end
    @(negedge sys_clk);
    frame_start = 1'b0;
    data_in     = 4'h0;
  endtask

  task automatic wait_bytes(input int base, input int n, input int budget);
    for (int c = 0; c < budget && (rx_cnt - base) < n; c++) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    n_checks++; if ({tx_valid, value_valid, busy, frame_dropped} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {tx_valid, value_valid, busy, frame_dropped}); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    n_checks++; if (value_out !== 32'h0) begin n_fail++; $display("FAIL reset_value_out: got %h expected 0", value_out); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int base;
    int lat;
    do_reset();
    tx_ready = 1'b1;
    base = rx_cnt;
    send_frame(32'h0000_04D2);
    n_checks++; if (value_valid !== 1'b1) begin n_fail++; $display("FAIL basic_vv: got %b expected 1", value_valid); end
    n_checks++; if (value_out !== 32'h4D2) begin n_fail++; $display("FAIL basic_value: got %h expected 4d2", value_out); end
    @(negedge sys_clk);
    lat = 1;
    n_checks++; if (value_valid !== 1'b0) begin n_fail++; $display("FAIL basic_vv_pulse: got %b expected 0", value_valid); end
    while (!tx_valid && lat < 100) begin @(negedge sys_clk); lat++; end
    n_checks++; if (lat < 33 || lat > 39) begin n_fail++; $display("FAIL basic_latency: got %0d expected 33..39", lat); end
    wait_bytes(base, 6, 200);
    n_checks++; if (rx_cnt - base !== 6) begin n_fail++; $display("FAIL basic_count: got %0d expected 6", rx_cnt - base); end
    n_checks++; if (rx_word[47:0] !== {"1234", 8'h0D, 8'h0A}) begin n_fail++;
      $display("FAIL basic_bytes: got %h expected %h", rx_word[47:0], {"1234", 8'h0D, 8'h0A}); end
    repeat (3) @(negedge sys_clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b expected 0", busy); end
  endtask

  task automatic test_zero();
    int base;
    int v0;
    do_reset();
    tx_ready = 1'b1;
    base = rx_cnt;
    send_frame(32'h0);
    wait_bytes(base, 3, 200);
    n_checks++; if (rx_cnt - base !== 3) begin n_fail++; $display("FAIL zero_count: got %0d expected 3", rx_cnt - base); end
    n_checks++; if (rx_word[23:0] !== {"0", 8'h0D, 8'h0A}) begin n_fail++;
      $display("FAIL zero_bytes: got %h expected 300d0a", rx_word[23:0]); end
    repeat (5) @(negedge sys_clk);
    base = rx_cnt;
    v0 = vv_cnt;
    send_frame(32'h0);
    repeat (80) @(negedge sys_clk);
    n_checks++; if (rx_cnt !== base) begin n_fail++; $display("FAIL zero_repeat_silent: got %0d expected 0", rx_cnt - base); end
    n_checks++; if (vv_cnt - v0 !== 1) begin n_fail++; $display("FAIL zero_repeat_vv: got %0d expected 1", vv_cnt - v0); end
  endtask

  task automatic test_backpressure();
    int base;
    int sv;
    do_reset();
    tx_ready = 1'b0;
    sv = stab_viol;
    base = rx_cnt;
    send_frame(32'hFFFF_FFFF);
    for (int c = 0; c < 2000 && (rx_cnt - base) < 12; c++) begin
      @(negedge sys_clk);
      tx_ready = 1'($urandom_range(0, 1));
    end
    tx_ready = 1'b1;
    n_checks++; if (rx_cnt - base !== 12) begin n_fail++; $display("FAIL bp_count: got %0d expected 12", rx_cnt - base); end
    n_checks++; if (rx_word[95:0] !== {"4294967295", 8'h0D, 8'h0A}) begin n_fail++;
      $display("FAIL bp_bytes: got %h expected %h", rx_word[95:0], {"4294967295", 8'h0D, 8'h0A}); end
    n_checks++; if (stab_viol - sv !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d violations expected 0", stab_viol - sv); end
  endtask

  task automatic test_overwrite();
    int base;
    int d0;
    do_reset();
    tx_ready = 1'b0;
    base = rx_cnt;
    d0 = drop_cnt;
    send_frame(32'h5);
    send_frame(32'h6);
    send_frame(32'h7);
    n_checks++; if (frame_dropped !== 1'b1) begin n_fail++; $display("FAIL ovw_drop_pulse: got %b expected 1", frame_dropped); end
    n_checks++; if (rx_cnt !== base) begin n_fail++; $display("FAIL ovw_stalled: got %0d expected 0", rx_cnt - base); end
    tx_ready = 1'b1;
    wait_bytes(base, 6, 400);
    repeat (100) @(negedge sys_clk);
    n_checks++; if (rx_cnt - base !== 6) begin n_fail++; $display("FAIL ovw_count: got %0d expected 6", rx_cnt - base); end
    n_checks++; if (rx_word[47:0] !== {"5", 8'h0D, 8'h0A, "7", 8'h0D, 8'h0A}) begin n_fail++;
      $display("FAIL ovw_bytes: got %h expected 350d0a370d0a", rx_word[47:0]); end
    n_checks++; if (drop_cnt - d0 !== 1) begin n_fail++; $display("FAIL ovw_drop_count: got %0d expected 1", drop_cnt - d0); end
  endtask

  task automatic test_restart();
    int base;
    int v0;
    logic [31:0] first_frame;
    do_reset();
    tx_ready = 1'b1;
    base = rx_cnt;
    v0 = vv_cnt;
    first_frame = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      frame_start = (i == 0);
      data_in     = first_frame[31-4*i -: 4];
    end
    send_frame(32'h7);
    n_checks++; if (value_out !== 32'h7) begin n_fail++; $display("FAIL restart_value: got %h expected 7", value_out); end
    wait_bytes(base, 3, 200);
    repeat (100) @(negedge sys_clk);
    n_checks++; if (rx_cnt - base !== 3) begin n_fail++; $display("FAIL restart_count: got %0d expected 3", rx_cnt - base); end
    n_checks++; if (rx_word[23:0] !== {"7", 8'h0D, 8'h0A}) begin n_fail++;
      $display("FAIL restart_bytes: got %h expected 370d0a", rx_word[23:0]); end
    n_checks++; if (vv_cnt - v0 !== 1) begin n_fail++; $display("FAIL restart_vv: got %0d expected 1", vv_cnt - v0); end
  endtask

  task automatic test_reset_midline();
    int base;
    do_reset();
    tx_ready = 1'b1;
    base = rx_cnt;
    send_frame(32'h0000_04D2);
    wait_bytes(base, 2, 200);
    tx_ready = 1'b0;
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", tx_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (rx_cnt - base !== 2) begin n_fail++; $display("FAIL midrst_partial: got %0d expected 2", rx_cnt - base); end
    n_checks++; if (rx_word[15:0] !== "12") begin n_fail++; $display("FAIL midrst_partial_bytes: got %h expected 3132", rx_word[15:0]); end
    base = rx_cnt;
    tx_ready = 1'b1;
    send_frame(32'h0000_04D2);
    wait_bytes(base, 6, 200);
    n_checks++; if (rx_cnt - base !== 6) begin n_fail++; $display("FAIL midrst_count: got %0d expected 6", rx_cnt - base); end
    n_checks++; if (rx_word[47:0] !== {"1234", 8'h0D, 8'h0A}) begin n_fail++;
      $display("FAIL midrst_bytes: got %h expected %h", rx_word[47:0], {"1234", 8'h0D, 8'h0A}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_overwrite();
    test_restart();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
